// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I encodings for result select and load type
package riscv_pkg;

    localparam logic [1:0] RESULT_ALU  = 2'b00;
    localparam logic [1:0] RESULT_LOAD = 2'b01;
    localparam logic [1:0] RESULT_PC4  = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - byte/half lane extraction and sign/zero extension of load data
module load_extend
    import riscv_pkg::*;
(
    input  logic [31:0] read_data,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] data_out
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // pick the addressed lane; halfwords only honour addr[1]
    always_comb begin
        byte_sel = read_data[7:0];
        case (addr)
            2'd0: byte_sel = read_data[7:0];
            2'd1: byte_sel = read_data[15:8];
            2'd2: byte_sel = read_data[23:16];
            2'd3: byte_sel = read_data[31:24];
            default: byte_sel = read_data[7:0];
        endcase
        half_sel = addr[1] ? read_data[31:16] : read_data[15:0];
    end

    // extend according to load type; unknown types behave as a full word
    always_comb begin
        data_out = read_data;
        case (funct3)
            F3_LB:   data_out = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data_out = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  data_out = {24'd0, byte_sel};
            F3_LHU:  data_out = {16'd0, half_sel};
            F3_LW:   data_out = read_data;
            default: data_out = read_data;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - MEM/WB register, result select, single-shot commit and retire counter
module writeback_stage
    import riscv_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_w,
    input  logic              flush_w,
    input  logic              valid_m,
    input  logic              reg_write_m,
    input  logic [1:0]        result_src_m,
    input  logic [2:0]        funct3_m,
    input  logic [4:0]        rd_m,
    input  logic [DATA_W-1:0] alu_result_m,
    input  logic [DATA_W-1:0] read_data_m,
    input  logic [DATA_W-1:0] pc_plus4_m,
    output logic              WE3,
    output logic [4:0]        A3,
    output logic [DATA_W-1:0] WD3,
    output logic              valid_w,
    output logic              reg_write_w,
    output logic [4:0]        rd_w,
    output logic [DATA_W-1:0] result_w,
    output logic [CNT_W-1:0]  retire_cnt
);

    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              reg_write_q, reg_write_d;
    logic [1:0]        result_src_q, result_src_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [4:0]        rd_q, rd_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] pc4_q, pc4_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              commit;
    logic              rd_nonzero;
    logic [31:0]       load_ext;
    logic [DATA_W-1:0] result;

    load_extend u_load_extend (
        .read_data (rdata_q),
        .addr      (alu_q[1:0]),
        .funct3    (funct3_q),
        .data_out  (load_ext)
    );

    // commit qualification: done marks a stalled instruction that already wrote/retired
    always_comb begin
        rd_nonzero = (rd_q != 5'd0);
        commit     = valid_q & ~done_q;
    end

    // result select; the reserved encoding yields zero
    always_comb begin
        result = '0;
        case (result_src_q)
            RESULT_ALU:  result = alu_q;
            RESULT_LOAD: result = load_ext;
            RESULT_PC4:  result = pc4_q;
            default:     result = '0;
        endcase
    end

    // next-state for the W register: flush beats stall, stall holds everything but records the commit
    always_comb begin
        valid_d      = valid_q;
        done_d       = done_q;
        reg_write_d  = reg_write_q;
        result_src_d = result_src_q;
        funct3_d     = funct3_q;
        rd_d         = rd_q;
        alu_d        = alu_q;
        rdata_d      = rdata_q;
        pc4_d        = pc4_q;
        cnt_d        = cnt_q + CNT_W'(commit);
        if (flush_w) begin
            valid_d = 1'b0;
            done_d  = 1'b0;
        end else if (stall_w) begin
            done_d = done_q | commit;
        end else begin
            valid_d      = valid_m;
            done_d       = 1'b0;
            reg_write_d  = reg_write_m;
            result_src_d = result_src_m;
            funct3_d     = funct3_m;
            rd_d         = rd_m;
            alu_d        = alu_result_m;
            rdata_d      = read_data_m;
            pc4_d        = pc_plus4_m;
        end
    end

    // W-stage state register with asynchronous reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q      <= 1'b0;
            done_q       <= 1'b0;
            reg_write_q  <= 1'b0;
            result_src_q <= 2'b00;
            funct3_q     <= 3'b000;
            rd_q         <= 5'd0;
            alu_q        <= '0;
            rdata_q      <= '0;
            pc4_q        <= '0;
            cnt_q        <= '0;
        end else begin
            valid_q      <= valid_d;
            done_q       <= done_d;
            reg_write_q  <= reg_write_d;
            result_src_q <= result_src_d;
            funct3_q     <= funct3_d;
            rd_q         <= rd_d;
            alu_q        <= alu_d;
            rdata_q      <= rdata_d;
            pc4_q        <= pc4_d;
            cnt_q        <= cnt_d;
        end
    end

    // regfile write port and forwarding outputs; x0 and the reserved select never write
    always_comb begin
        WE3         = commit & reg_write_q & rd_nonzero & (result_src_q != 2'b11);
        A3          = rd_q;
        WD3         = result;
        valid_w     = valid_q;
        reg_write_w = valid_q & reg_write_q & rd_nonzero;
        rd_w        = rd_q;
        result_w    = result;
        retire_cnt  = cnt_q;
    end

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - directed-vector self-checking bench for writeback_stage
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_w, flush_w, valid_m, reg_write_m;
    logic [1:0]  result_src_m;
    logic [2:0]  funct3_m;
    logic [4:0]  rd_m;
    logic [31:0] alu_result_m, read_data_m, pc_plus4_m;

    logic        WE3, valid_w, reg_write_w;
    logic [4:0]  A3, rd_w;
    logic [31:0] WD3, result_w, retire_cnt;

    logic        we3_b, valid_w_b, reg_write_w_b;
    logic [4:0]  a3_b, rd_w_b;
    logic [31:0] wd3_b, result_w_b;
    logic [3:0]  retire_cnt_b;

    int vectors = 0;
    int miscompares = 0;
    int exp_cnt = 0;
    int we_hits;

    always #5 clk = ~clk;

    writeback_stage dut (
        .clk(clk), .rst(rst), .stall_w(stall_w), .flush_w(flush_w), .valid_m(valid_m),
        .reg_write_m(reg_write_m), .result_src_m(result_src_m), .funct3_m(funct3_m), .rd_m(rd_m),
        .alu_result_m(alu_result_m), .read_data_m(read_data_m), .pc_plus4_m(pc_plus4_m),
        .WE3(WE3), .A3(A3), .WD3(WD3), .valid_w(valid_w), .reg_write_w(reg_write_w),
        .rd_w(rd_w), .result_w(result_w), .retire_cnt(retire_cnt)
    );

    writeback_stage #(.DATA_W(32), .CNT_W(4)) dut_cnt4 (
        .clk(clk), .rst(rst), .stall_w(stall_w), .flush_w(flush_w), .valid_m(valid_m),
        .reg_write_m(reg_write_m), .result_src_m(result_src_m), .funct3_m(funct3_m), .rd_m(rd_m),
        .alu_result_m(alu_result_m), .read_data_m(read_data_m), .pc_plus4_m(pc_plus4_m),
        .WE3(we3_b), .A3(a3_b), .WD3(wd3_b), .valid_w(valid_w_b), .reg_write_w(reg_write_w_b),
        .rd_w(rd_w_b), .result_w(result_w_b), .retire_cnt(retire_cnt_b)
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // present one live instruction for a single edge, then return M to idle
    task automatic issue(input logic rw, input logic [1:0] src, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] rdata, input logic [31:0] pc4);
        valid_m      = 1'b1;
        reg_write_m  = rw;
        result_src_m = src;
        funct3_m     = f3;
        rd_m         = rd;
        alu_result_m = alu;
        read_data_m  = rdata;
        pc_plus4_m   = pc4;
        step();
        valid_m = 1'b0;
        exp_cnt++;
    endtask

    initial begin
        // 1: reset with junk on the inputs
        rst          = 1'b0;
        stall_w      = 1'b0;
        flush_w      = 1'b0;
        valid_m      = 1'b1;
        reg_write_m  = 1'b1;
        result_src_m = 2'b00;
        funct3_m     = 3'($urandom);
        rd_m         = 5'd9;
        alu_result_m = $urandom;
        read_data_m  = $urandom;
        pc_plus4_m   = $urandom;
        step();
        step();
        check_vec("rst_we3", {31'd0, WE3}, 32'd0);
        check_vec("rst_valid", {31'd0, valid_w}, 32'd0);
        check_vec("rst_cnt", retire_cnt, 32'd0);
        check_vec("rst_a3", {27'd0, A3}, 32'd0);
        check_vec("rst_wd3", WD3, 32'd0);
        valid_m = 1'b0;
        rst     = 1'b1;
        step();
        check_vec("post_rst_valid", {31'd0, valid_w}, 32'd0);
        check_vec("post_rst_cnt", retire_cnt, 32'd0);

        // 2: ALU write
        issue(1'b1, 2'b00, 3'b010, 5'd5, 32'h0000_1234, 32'h0, 32'h0);
        check_vec("alu_we3", {31'd0, WE3}, 32'd1);
        check_vec("alu_a3", {27'd0, A3}, 32'd5);
        check_vec("alu_wd3", WD3, 32'h0000_1234);
        check_vec("alu_fwd", {26'd0, reg_write_w, rd_w}, {26'd0, 1'b1, 5'd5});
        step();
        check_vec("alu_cnt", retire_cnt, 32'd1);
        check_vec("alu_idle_we3", {31'd0, WE3}, 32'd0);

        // 3: load extraction from 0x80FF7F01
        issue(1'b1, 2'b01, 3'b000, 5'd10, 32'h0000_1002, 32'h80FF_7F01, 32'h0);
        check_vec("lb_a2", WD3, 32'hFFFF_FFFF);
        issue(1'b1, 2'b01, 3'b100, 5'd11, 32'h0000_1003, 32'h80FF_7F01, 32'h0);
        check_vec("lbu_a3", WD3, 32'h0000_0080);
        issue(1'b1, 2'b01, 3'b001, 5'd12, 32'h0000_1002, 32'h80FF_7F01, 32'h0);
        check_vec("lh_a2", WD3, 32'hFFFF_80FF);
        issue(1'b1, 2'b01, 3'b001, 5'd12, 32'h0000_1003, 32'h80FF_7F01, 32'h0);
        check_vec("lh_a3", WD3, 32'hFFFF_80FF);
        issue(1'b1, 2'b01, 3'b101, 5'd13, 32'h0000_1000, 32'h80FF_7F01, 32'h0);
        check_vec("lhu_a0", WD3, 32'h0000_7F01);
        issue(1'b1, 2'b01, 3'b000, 5'd13, 32'h0000_1001, 32'h80FF_7F01, 32'h0);
        check_vec("lb_a1", WD3, 32'h0000_007F);
        issue(1'b1, 2'b01, 3'b010, 5'd14, 32'h0000_1003, 32'h80FF_7F01, 32'h0);
        check_vec("lw", WD3, 32'h80FF_7F01);
        check_vec("lw_we3", {31'd0, WE3}, 32'd1);
        step();
        check_vec("load_cnt", retire_cnt, 32'd8);

        // 4: stall held for three edges
        issue(1'b1, 2'b00, 3'b010, 5'd7, 32'h0000_0077, 32'h0, 32'h0);
        stall_w      = 1'b1;
        valid_m      = 1'b1;
        rd_m         = 5'd9;
        alu_result_m = 32'h0000_0099;
        we_hits      = 0;
        for (int i = 0; i < 4; i++) begin
            if (WE3) we_hits++;
            check_vec($sformatf("stall_rw_%0d", i), {31'd0, reg_write_w}, 32'd1);
            check_vec($sformatf("stall_rd_%0d", i), {27'd0, rd_w}, 32'd7);
            check_vec($sformatf("stall_res_%0d", i), result_w, 32'h0000_0077);
            if (i < 3) step();
        end
        check_vec("stall_we_hits", we_hits, 32'd1);
        stall_w = 1'b0;
        valid_m = 1'b0;
        step();
        check_vec("stall_release_valid", {31'd0, valid_w}, 32'd0);
        check_vec("stall_cnt", retire_cnt, 32'(exp_cnt));

        // 5: flush wins over stall, x0, reserved select
        issue(1'b1, 2'b00, 3'b010, 5'd3, 32'h0000_0033, 32'h0, 32'h0);
        flush_w = 1'b1;
        stall_w = 1'b1;
        valid_m = 1'b1;
        rd_m    = 5'd4;
        step();
        check_vec("flush_valid", {31'd0, valid_w}, 32'd0);
        check_vec("flush_we3", {31'd0, WE3}, 32'd0);
        check_vec("flush_rw", {31'd0, reg_write_w}, 32'd0);
        flush_w = 1'b0;
        stall_w = 1'b0;
        valid_m = 1'b0;
        step();
        check_vec("flush_cnt", retire_cnt, 32'(exp_cnt));
        issue(1'b1, 2'b00, 3'b010, 5'd0, 32'h0000_5555, 32'h0, 32'h0);
        check_vec("x0_we3", {31'd0, WE3}, 32'd0);
        check_vec("x0_rw", {31'd0, reg_write_w}, 32'd0);
        check_vec("x0_valid", {31'd0, valid_w}, 32'd1);
        issue(1'b1, 2'b11, 3'b010, 5'd6, 32'h0000_6666, 32'h1234_5678, 32'h0000_0200);
        check_vec("rsv_we3", {31'd0, WE3}, 32'd0);
        check_vec("rsv_wd3", WD3, 32'd0);
        step();
        check_vec("x0_rsv_cnt", retire_cnt, 32'(exp_cnt));
        check_vec("cnt4_track", {28'd0, retire_cnt_b}, 32'(exp_cnt % 16));

        // 6: JAL link value
        issue(1'b1, 2'b10, 3'b010, 5'd1, 32'h0000_DEAD, 32'h0, 32'h0000_0104);
        check_vec("jal_wd3", WD3, 32'h0000_0104);
        check_vec("jal_a3", {27'd0, A3}, 32'd1);
        check_vec("jal_we3", {31'd0, WE3}, 32'd1);

        // reset in the middle of a stall discards the instruction at once
        issue(1'b1, 2'b00, 3'b010, 5'd8, 32'h0000_0088, 32'h0, 32'h0);
        stall_w = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check_vec("rst_stall_we3", {31'd0, WE3}, 32'd0);
        check_vec("rst_stall_valid", {31'd0, valid_w}, 32'd0);
        check_vec("rst_stall_cnt", retire_cnt, 32'd0);
        step();
        stall_w = 1'b0;
        rst     = 1'b1;
        exp_cnt = 0;
        step();

        // 16 back-to-back commits wrap a 4-bit counter to zero
        for (int i = 0; i < 16; i++)
            issue(1'b1, 2'b00, 3'b010, 5'(i + 1), 32'(i), 32'h0, 32'h0);
        step();
        check_vec("wrap_cnt4", {28'd0, retire_cnt_b}, 32'd0);
        check_vec("wrap_cnt32", retire_cnt, 32'd16);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
